// File: rtl/pipe_ctrl_if.sv
// Control-unit bus: instruction fields and ALU flags in, per-stage pipeline controls out.
interface pipe_ctrl_if #(
    parameter int ALUCTRL_W = 4
) ();
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic [3:0]           Cond;
    logic [3:0]           ALUFlags;
    logic                 FlushE;

    logic                 RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUSrcD, LinkD, IllegalD;
    logic [ALUCTRL_W-1:0] ALUControlD;
    logic [1:0]           FlagWriteD, ImmSrcD, RegSrcD;

    logic                 RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE, ALUSrcE, LinkE;
    logic [ALUCTRL_W-1:0] ALUControlE;
    logic [1:0]           FlagWriteE, ImmSrcE;
    logic [3:0]           CondE;
    logic                 CondExE, BranchTakenE;
    logic [3:0]           FlagsQ;

    logic                 RegWriteM, MemWriteM, MemToRegM, PCSrcM, LinkM;
    logic                 RegWriteW, MemToRegW, PCSrcW, LinkW;
    logic                 PCWrPending;

    modport master (
        output Op, Funct, Rd, Cond, ALUFlags, FlushE,
        input  RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUSrcD, LinkD, IllegalD,
        input  ALUControlD, FlagWriteD, ImmSrcD, RegSrcD,
        input  RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE, ALUSrcE, LinkE,
        input  ALUControlE, FlagWriteE, ImmSrcE, CondE, CondExE, BranchTakenE, FlagsQ,
        input  RegWriteM, MemWriteM, MemToRegM, PCSrcM, LinkM,
        input  RegWriteW, MemToRegW, PCSrcW, LinkW, PCWrPending
    );

    modport slave (
        input  Op, Funct, Rd, Cond, ALUFlags, FlushE,
        output RegWriteD, MemWriteD, MemToRegD, BranchD, PCSrcD, ALUSrcD, LinkD, IllegalD,
        output ALUControlD, FlagWriteD, ImmSrcD, RegSrcD,
        output RegWriteE, MemWriteE, MemToRegE, BranchE, PCSrcE, ALUSrcE, LinkE,
        output ALUControlE, FlagWriteE, ImmSrcE, CondE, CondExE, BranchTakenE, FlagsQ,
        output RegWriteM, MemWriteM, MemToRegM, PCSrcM, LinkM,
        output RegWriteW, MemToRegW, PCSrcW, LinkW, PCWrPending
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit for the 5-stage ARM-subset core: decode, E/M/W control
// registers, NZCV flag register and Execute-stage condition check.
module pipe_ctrl_unit #(
    parameter int ALUCTRL_W  = 4,
    parameter bit SUPPORT_BL = 1'b1,
    parameter bit FLAG_SPLIT = 1'b1
) (
    input logic         clk,
    input logic         reset,
    pipe_ctrl_if.slave  bus
);

    logic       regWrite, memWrite, memToReg, branch, aluSrc, link, illegal;
    logic [3:0] aluCmd;
    logic [1:0] flagWrite, immSrc, regSrc;
    logic       isArith;
    logic       condEx;
    logic       n, z, c, v;

    // Decode: Op/Funct/Rd into the Decode-stage control word.
    always_comb begin
        regWrite  = 1'b0;
        memWrite  = 1'b0;
        memToReg  = 1'b0;
        branch    = 1'b0;
        aluSrc    = 1'b0;
        link      = 1'b0;
        illegal   = 1'b0;
        aluCmd    = 4'b0000;
        flagWrite = 2'b00;
        immSrc    = 2'b00;
        regSrc    = 2'b00;
        isArith   = 1'b0;
        case (bus.Op)
            2'b00: begin
                aluCmd   = bus.Funct[4:1];
                aluSrc   = bus.Funct[5];
                regWrite = (aluCmd[3:2] != 2'b10);
                isArith  = aluCmd inside {4'b0010, 4'b0011, 4'b0100, 4'b0101,
                                          4'b0110, 4'b0111, 4'b1010, 4'b1011};
                if (bus.Funct[0])
                    flagWrite = (isArith || !FLAG_SPLIT) ? 2'b11 : 2'b10;
            end
            2'b01: begin
                regWrite = bus.Funct[0];
                memToReg = bus.Funct[0];
                memWrite = ~bus.Funct[0];
                aluSrc   = ~bus.Funct[5];
                immSrc   = 2'b01;
                regSrc   = 2'b10;
                aluCmd   = bus.Funct[3] ? 4'b0100 : 4'b0010;
            end
            2'b10: begin
                branch   = 1'b1;
                aluSrc   = 1'b1;
                immSrc   = 2'b10;
                regSrc   = 2'b01;
                aluCmd   = 4'b0100;
                link     = SUPPORT_BL & bus.Funct[4];
                regWrite = SUPPORT_BL & bus.Funct[4];
            end
            default: illegal = 1'b1;
        endcase
    end

    assign bus.RegWriteD   = regWrite;
    assign bus.MemWriteD   = memWrite;
    assign bus.MemToRegD   = memToReg;
    assign bus.BranchD     = branch;
    assign bus.PCSrcD      = (bus.Op != 2'b10) & regWrite & (bus.Rd == 4'hF);
    assign bus.ALUSrcD     = aluSrc;
    assign bus.LinkD       = link;
    assign bus.IllegalD    = illegal;
    assign bus.ALUControlD = ALUCTRL_W'(aluCmd);
    assign bus.FlagWriteD  = flagWrite;
    assign bus.ImmSrcD     = immSrc;
    assign bus.RegSrcD     = regSrc;

    // Decode->Execute register; a flush inserts a bubble that always passes its condition.
    always_ff @(posedge clk) begin
        if (reset || bus.FlushE) begin
            bus.RegWriteE   <= 1'b0;
            bus.MemWriteE   <= 1'b0;
            bus.MemToRegE   <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.PCSrcE      <= 1'b0;
            bus.ALUSrcE     <= 1'b0;
            bus.LinkE       <= 1'b0;
            bus.ALUControlE <= '0;
            bus.FlagWriteE  <= 2'b00;
            bus.ImmSrcE     <= 2'b00;
            bus.CondE       <= 4'hE;
        end else begin
            bus.RegWriteE   <= bus.RegWriteD;
            bus.MemWriteE   <= bus.MemWriteD;
            bus.MemToRegE   <= bus.MemToRegD;
            bus.BranchE     <= bus.BranchD;
            bus.PCSrcE      <= bus.PCSrcD;
            bus.ALUSrcE     <= bus.ALUSrcD;
            bus.LinkE       <= bus.LinkD;
            bus.ALUControlE <= bus.ALUControlD;
            bus.FlagWriteE  <= bus.FlagWriteD;
            bus.ImmSrcE     <= bus.ImmSrcD;
            bus.CondE       <= bus.Cond;
        end
    end

    // Condition check of the Execute instruction against the architectural flags.
    always_comb begin
        {n, z, c, v} = bus.FlagsQ;
        condEx = 1'b0;
        case (bus.CondE)
            4'b0000: condEx = z;
            4'b0001: condEx = ~z;
            4'b0010: condEx = c;
            4'b0011: condEx = ~c;
            4'b0100: condEx = n;
            4'b0101: condEx = ~n;
            4'b0110: condEx = v;
            4'b0111: condEx = ~v;
            4'b1000: condEx = c & ~z;
            4'b1001: condEx = ~c | z;
            4'b1010: condEx = (n == v);
            4'b1011: condEx = (n != v);
            4'b1100: condEx = ~z & (n == v);
            4'b1101: condEx = z | (n != v);
            4'b1110: condEx = 1'b1;
            default: condEx = 1'b0;
        endcase
    end

    assign bus.CondExE      = condEx;
    assign bus.BranchTakenE = bus.BranchE & condEx;
    assign bus.PCWrPending  = bus.PCSrcD | bus.PCSrcE | bus.PCSrcM;

    // NZCV register with independent NZ and CV write enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.FlagsQ <= 4'b0000;
        end else if (condEx) begin
            if (bus.FlagWriteE[1]) bus.FlagsQ[3:2] <= bus.ALUFlags[3:2];
            if (bus.FlagWriteE[0]) bus.FlagsQ[1:0] <= bus.ALUFlags[1:0];
        end
    end

    // Execute->Memory register; write-side controls are squashed by a failed condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.RegWriteM <= 1'b0;
            bus.MemWriteM <= 1'b0;
            bus.MemToRegM <= 1'b0;
            bus.PCSrcM    <= 1'b0;
            bus.LinkM     <= 1'b0;
        end else begin
            bus.RegWriteM <= bus.RegWriteE & condEx;
            bus.MemWriteM <= bus.MemWriteE & condEx;
            bus.MemToRegM <= bus.MemToRegE;
            bus.PCSrcM    <= (bus.PCSrcE | bus.BranchE) & condEx;
            bus.LinkM     <= bus.LinkE & condEx;
        end
    end

    // Memory->Writeback register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.RegWriteW <= 1'b0;
            bus.MemToRegW <= 1'b0;
            bus.PCSrcW    <= 1'b0;
            bus.LinkW     <= 1'b0;
        end else begin
            bus.RegWriteW <= bus.RegWriteM;
            bus.MemToRegW <= bus.MemToRegM;
            bus.PCSrcW    <= bus.PCSrcM;
            bus.LinkW     <= bus.LinkM;
        end
    end

endmodule
